// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//   SPI master transmitter, mode 0 (sclk idles low, data changes on the falling
//   edge, sampled by the slave on the rising edge), MSB first. One word per
//   transfer: a setup interval with cs_n low, MSB sclk periods, a hold
//   interval, then a single done cycle with cs_n released.
//
//   Optional receive path: define SPI_MASTER_MISO_EN to add the miso input and
//   the rx_data output. miso is captured once per sclk period, at the start of
//   the high phase. rx_data is loaded as the block enters the done cycle.
//
// Parameters
//   MSB     transfer word width in bits (2..32)
//   CLKDIV  clk cycles per sclk half-period (1..255)
//
// Ports
//   clk      system clock, all state changes on its rising edge
//   rst_n    asynchronous active-low reset
//   start    transfer request; accepted in IDLE, and in DONE for back-to-back
//   tx_data  word to send, captured when start is accepted
//   busy     high from the first setup cycle through the done cycle
//   done     one-cycle completion pulse
//   sclk     SPI clock
//   cs_n     SPI chip select, active low
//   mosi     serial data out, forced low while cs_n is high
//   miso     serial data in            (SPI_MASTER_MISO_EN only)
//   rx_data  last received word        (SPI_MASTER_MISO_EN only)
// -----------------------------------------------------------------------------
module spi_master_tx #(
   parameter int MSB    = 8,
   parameter int CLKDIV = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [MSB-1:0] tx_data,
   output logic           busy,
   output logic           done,
   output logic           sclk,
   output logic           cs_n,
   output logic           mosi
`ifdef SPI_MASTER_MISO_EN
   ,
   input  logic           miso,
   output logic [MSB-1:0] rx_data
`endif
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
   localparam logic [5:0] BIT_LAST = 6'(MSB - 1);

   state_t         state, state_nx;
   logic [7:0]     div_cnt, div_cnt_nx;
   logic [5:0]     bit_cnt, bit_cnt_nx;
   logic           hi, hi_nx;         // current sclk phase while in SHIFT
   logic           load, shift_en;
   logic           div_wrap;
   logic [MSB-1:0] tx_sh;

   assign div_wrap = (div_cnt == DIV_LAST);

   // control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         hi      <= 1'b0;
      end else begin
         state   <= state_nx;
         div_cnt <= div_cnt_nx;
         bit_cnt <= bit_cnt_nx;
         hi      <= hi_nx;
      end
   end

   // transmit shift register; its contents only matter while cs_n is low
   always_ff @(posedge clk) begin
      if (load)
         tx_sh <= tx_data;
      else if (shift_en)
         tx_sh <= {tx_sh[MSB-2:0], 1'b0};
   end

   always_comb begin
      state_nx   = state;
      div_cnt_nx = div_wrap ? 8'd0 : div_cnt + 8'd1;
      bit_cnt_nx = bit_cnt;
      hi_nx      = hi;
      load       = 1'b0;
      shift_en   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      sclk       = 1'b0;
      cs_n       = 1'b0;
      case (state)
         IDLE: begin
            busy       = 1'b0;
            cs_n       = 1'b1;
            div_cnt_nx = '0;
            bit_cnt_nx = '0;
            hi_nx      = 1'b0;
            if (start) begin
               load     = 1'b1;
               state_nx = SETUP;
            end
         end
         SETUP: begin
            if (div_wrap) begin
               state_nx = SHIFT;
               hi_nx    = 1'b1;
            end
         end
         SHIFT: begin
            sclk = hi;
            if (div_wrap) begin
               if (hi) begin
                  // falling edge: advance to the next bit, except after the
                  // last bit so mosi stays put through HOLD
                  hi_nx    = 1'b0;
                  shift_en = (bit_cnt != BIT_LAST);
               end else if (bit_cnt == BIT_LAST) begin
                  state_nx = HOLD;
               end else begin
                  hi_nx      = 1'b1;
                  bit_cnt_nx = bit_cnt + 6'd1;
               end
            end
         end
         HOLD: begin
            if (div_wrap)
               state_nx = DONE;
         end
         DONE: begin
            cs_n       = 1'b1;
            done       = 1'b1;
            div_cnt_nx = '0;
            bit_cnt_nx = '0;
            hi_nx      = 1'b0;
            // a start seen here chains straight into the next setup so cs_n
            // is released for this single cycle only
            if (start) begin
               load     = 1'b1;
               state_nx = SETUP;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mosi = cs_n ? 1'b0 : tx_sh[MSB-1];

`ifdef SPI_MASTER_MISO_EN
   logic [MSB-1:0] rx_sh;

   // capture on the first clk of each high phase, right after sclk rises
   always_ff @(posedge clk) begin
      if (state == SHIFT && hi && div_cnt == 8'd0)
         rx_sh <= {rx_sh[MSB-2:0], miso};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rx_data <= '0;
      else if (state == HOLD && div_wrap)
         rx_data <= rx_sh;
   end
`endif

endmodule
